// File: rtl/fp_normalizer.sv
// Post-adder normaliser for the binary32 add/sub datapath: shifts the raw
// mantissa sum one position per clock, then packs the result word and status flags.
module fp_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W:0]           in_sum,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic                      in_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   out_result,
  output logic                      out_zero,
  output logic                      out_overflow,
  output logic                      out_denorm,
  output logic [$clog2(MANT_W)-1:0] shift_count,
  output logic                      busy
);

  localparam int RES_W = EXP_W + MANT_W;
  localparam int SC_W  = $clog2(MANT_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  logic [1:0]        state_q,     state_d;
  logic [MANT_W:0]   mant_q,      mant_d;
  logic [EXP_W-1:0]  exp_q,       exp_d;
  logic              sign_q,      sign_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  result_q,    result_d;
  logic              zero_q,      zero_d;
  logic              ovf_q,       ovf_d;
  logic              denorm_q,    denorm_d;
  logic [SC_W-1:0]   sc_q,        sc_d;

  logic [EXP_W-1:0]  exp_inc;
  assign exp_inc = exp_q + EXP_ONE;

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    denorm_d    = denorm_q;
    sc_d        = sc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mant_d  = in_sum;
          exp_d   = (in_exp == '0) ? EXP_ONE : in_exp;
          sign_d  = in_sign;
          sc_d    = '0;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // One decision per clock; the priority order below defines the result.
        if (mant_q == '0) begin
          result_d = '0;
          zero_d   = 1'b1;
          state_d  = S_DONE;
        end else if (mant_q[MANT_W]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_d = {sign_q, EXP_MAX, {(MANT_W-1){1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_inc, mant_q[MANT_W-1:1]};
          end
          state_d = S_DONE;
        end else if (mant_q[MANT_W-1]) begin
          result_d = {sign_q, exp_q, mant_q[MANT_W-2:0]};
          state_d  = S_DONE;
        end else if (exp_q == EXP_ONE) begin
          result_d = {sign_q, {EXP_W{1'b0}}, mant_q[MANT_W-2:0]};
          denorm_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
          sc_d   = sc_q + SC_W'(1);
        end
      end

      S_DONE: begin
        // The result settles one cycle before out_valid rises.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          zero_d      = 1'b0;
          ovf_d       = 1'b0;
          denorm_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; next-state values come
  // from the always_comb above, which assigns every _d a default to avoid latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      denorm_q    <= 1'b0;
      sc_q        <= '0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      denorm_q    <= denorm_d;
      sc_q        <= sc_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_denorm   = denorm_q;
  assign shift_count  = sc_q;

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Downstream stage of the 24-bit mantissa adder_subtractor in the single-precision FP add/sub datapath.
- Takes the 25-bit raw mantissa sum, the effective (larger) biased exponent and the result sign.
- Normalises iteratively: at most one right shift, or one left shift per clock.
- Packs an IEEE-754 binary32 word with status flags. Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; sum input is MANT_W+1 bits.
- EXP_W, 8, biased exponent width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a sum/exponent/sign triple.
- in_ready  output  1  high only in IDLE; transfer when in_valid && in_ready at an edge.
- in_sum  input  25  raw sum from adder_subtractor; bit24 = carry-out, bit23 = hidden-bit position.
- in_exp  input  8  biased exponent of the larger operand; 0 is treated as 1; 255 is not allowed (specials are handled upstream).
- in_sign  input  1  result sign.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result when high with out_valid.
- out_result  output  32  {sign, exp[7:0], frac[22:0]}.
- out_zero  output  1  result is +0.
- out_overflow  output  1  result is infinity due to exponent overflow.
- out_denorm  output  1  result exponent field is 0 with nonzero fraction.
- shift_count  output  5  number of left shifts performed for the current/last result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE.
  - All output registers go to 0: out_valid, out_result, flags, shift_count.
  - in_ready=1 after reset deasserts. Any operation in progress is discarded and produces no output.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On accept: mant<=in_sum, exp<=(in_exp==0 ? 1 : in_exp), sign<=in_sign, shift_count<=0, go to NORM.
- NORM: one decision per cycle, in this priority order.
  1. mant==0: result=32'h00000000 (sign forced 0), out_zero=1, go to DONE.
  2. mant[24]=1: mant>>=1 (LSB truncated), exp+=1.
     - If the new exp==255: result={sign,8'hFF,23'h0} and out_overflow=1.
     - Otherwise: result={sign,exp+1,mant[23:1]}.
     - Go to DONE.
  3. mant[23]=1: result={sign,exp,mant[22:0]}, go to DONE.
  4. exp==1 (mant[23]=0): result={sign,8'h00,mant[22:0]}, out_denorm=1, go to DONE.
  5. Otherwise: mant<<=1, exp-=1, shift_count+=1, stay in NORM.
- DONE:
  - out_valid=1; out_result, flags and shift_count are held stable.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 during NORM and DONE. No input bypass: a new accept is possible one cycle after the result is taken.
- Latency (accept edge = edge 0): out_valid rises after edge 2 when no left shift is needed; after edge 2+k for k left shifts. Maximum k=23, giving 25 edges.
- Rounding: truncation only. Bits shifted out on the right are dropped.
- Flags are mutually exclusive. All flags clear on the edge that leaves DONE.
- in_sum, in_exp and in_sign are ignored when not accepted. in_valid may drop without being accepted, with no side effects.

Test Plan:
- sum=25'h0800000, exp=127, sign=0 -> out_result=32'h3F800000; out_valid after edge 2; shift_count=0; no flags.
- sum=25'h1000000, exp=127 -> 32'h40000000. Then sum=25'h1000000, exp=254, sign=1 -> 32'hFF800000 with out_overflow=1.
- sum=25'h0000001, exp=127 -> 32'h34000000; shift_count=23; out_valid after edge 25; in_ready=0 throughout.
- sum=25'h0000100, exp=5, sign=1 -> 4 shifts, then exp=1 stop -> 32'h80001000; out_denorm=1; shift_count=4. Then sum=0, exp=90, sign=1 -> 32'h00000000 with out_zero=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> result and flags stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 on the next cycle, and a second operand is accepted and processed correctly.
- Assert reset for one cycle mid-NORM (sum=25'h0000001 case, after 5 shifts) -> immediate IDLE, out_valid=0, all outputs 0. The next operand (25'h0800000, exp=127) yields 32'h3F800000 with shift_count=0.
